icache_responder: RTL



---
 rtl/icache_responder.sv | 129 ++++++++++++
 1 files changed

// File: rtl/icache_responder.sv
// ---------------------------------------------------------------------------
// icache_responder
//   Direct-mapped, one-word-per-block, read-only instruction cache sitting
//   between the fetch stage and the memory controller. A lookup hit answers
//   in the same cycle. A miss latches the word address, requests it from
//   memory, fills the frame, and returns to IDLE. The fetch then hits on the
//   retry.
//
// Ports
//   CLK, RST      clock; synchronous active-high reset
//   imemREN       fetch request from the datapath
//   imemaddr      fetch byte address (bits [1:0] ignored)
//   ihit          request served this cycle, imemload valid
//   imemload      instruction word (0 when not hitting)
//   iREN          memory read request (high while in MISS)
//   iaddr         word-aligned memory address of the outstanding fill
//   iwait         memory busy; low with iREN high means iload is valid
//   iload         memory read data
//   hit_count     saturating count of hits
//   miss_count    saturating count of misses started
// ---------------------------------------------------------------------------
module icache_responder #(
  parameter int NSETS = 16,
  parameter int IDX_W = 4,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             imemREN,
  input  logic [31:0]      imemaddr,
  output logic             ihit,
  output logic [31:0]      imemload,
  output logic             iREN,
  output logic [31:0]      iaddr,
  input  logic             iwait,
  input  logic [31:0]      iload,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int TAG_W = 32 - IDX_W - 2;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MISS = 1'b1;

  logic [0:0]       r_state;
  logic [29:0]      r_iaddr_word;   // only the word address is kept
  logic [CNT_W-1:0] r_hit_count;
  logic [CNT_W-1:0] r_miss_count;

  logic             r_valid [NSETS];
  logic [TAG_W-1:0] r_tag   [NSETS];
  logic [31:0]      r_data  [NSETS];

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic [IDX_W-1:0] w_fill_idx;
  logic [TAG_W-1:0] w_fill_tag;
  logic             w_hit;
  logic             w_miss_start;
  logic             w_fill;
  logic             w_unused;

  assign w_idx      = imemaddr[IDX_W+1:2];
  assign w_tag      = imemaddr[31:IDX_W+2];
  assign w_fill_idx = r_iaddr_word[IDX_W-1:0];
  assign w_fill_tag = r_iaddr_word[29:IDX_W];

  // Byte offset plays no part in the lookup.
  assign w_unused = ^imemaddr[1:0];

  assign w_hit        = (r_state == IDLE) & imemREN & r_valid[w_idx] &
                        (r_tag[w_idx] == w_tag);
  assign w_miss_start = (r_state == IDLE) & imemREN & ~w_hit;
  // The fill is gated by reset so an abandoned transaction writes nothing.
  assign w_fill       = (r_state == MISS) & ~iwait & ~RST;

  // Reset forces the handshake outputs low without waiting for the edge.
  assign ihit       = w_hit & ~RST;
  assign imemload   = ihit ? r_data[w_idx] : 32'd0;
  assign iREN       = (r_state == MISS) & ~RST;
  assign iaddr      = {r_iaddr_word, 2'b00};
  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= IDLE;
      r_iaddr_word <= '0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hit) begin
            if (r_hit_count != {CNT_W{1'b1}})
              r_hit_count <= r_hit_count + CNT_W'(1);
          end else if (w_miss_start) begin
            r_iaddr_word <= imemaddr[31:2];
            if (r_miss_count != {CNT_W{1'b1}})
              r_miss_count <= r_miss_count + CNT_W'(1);
            r_state <= MISS;
          end
        end
        MISS: begin
          if (!iwait)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // One register set per frame; the fill always targets the latched address.
  generate
    for (genvar gi = 0; gi < NSETS; gi++) begin : g_frame
      always_ff @(posedge CLK) begin
        if (RST) begin
          r_valid[gi] <= 1'b0;
        end else if (w_fill && (w_fill_idx == IDX_W'(gi))) begin
          r_valid[gi] <= 1'b1;
          r_tag[gi]   <= w_fill_tag;
          r_data[gi]  <= iload;
        end
      end
    end
  endgenerate

endmodule
